key_debounce_fsm: RTL and testbench
===================================

Name: key_debounce_fsm

Overview:
- Input-side counterpart to the board's timed LED drivers: takes one raw mechanical key, synchronises it, debounces it with a timed counter FSM, and emits clean event pulses.
- Outputs: press pulse, release pulse, long-press pulse and a stable pressed level.
- Consumers are LED/beeper/control logic running on the same sys_clk.

Parameters:
- DEBOUNCE_MAX, 20'd999_999: last count of the debounce window. The window is DEBOUNCE_MAX+1 cycles (20 ms at 50 MHz). Counter width is 20 bits and must hold this value.
- LONG_MAX, 6'd49: number of completed debounce windows held pressed before key_long fires (50 windows = 1 s). Must be ≥1.
- KEY_ACTIVE_LOW, 1'b1: 1 means key_in low = pressed; 0 means key_in high = pressed.

Ports:
- sys_clk  input  1  system clock, single clock domain.
- sys_rst  input  1  synchronous, active-high reset.
- key_in  input  1  raw asynchronous key pin.
- key_press  output  1  one-cycle pulse on debounced press.
- key_release  output  1  one-cycle pulse on debounced release.
- key_long  output  1  one-cycle pulse, at most once per press.
- key_state  output  1  debounced level; 1 = pressed.

Behaviour:
- Interface: one clock, sys_clk. sys_rst is synchronous and active-high and is sampled only on the rising edge of sys_clk.
- Reset values:
  - key_press, key_release, key_long, key_state = 0.
  - FSM = IDLE; all counters = 0.
  - Synchroniser flops reset to the released pin level (1 when KEY_ACTIVE_LOW).
- Synchroniser: 2 flip-flops on key_in, then normalised to pressed/released using KEY_ACTIVE_LOW. Nothing else samples key_in.
- States: IDLE, PRESS_FILT, PRESSED, RELEASE_FILT. Encoding is 2-bit binary.
- IDLE:
  - Synchronised pressed → PRESS_FILT, dbc_cnt=0.
- PRESS_FILT:
  - Released seen → IDLE, no pulse.
  - Pressed and dbc_cnt==DEBOUNCE_MAX → PRESSED; key_press=1 for one cycle; key_state=1; hold_cnt=0; tick_cnt=0.
  - Otherwise dbc_cnt++.
- PRESSED:
  - tick_cnt counts 0..DEBOUNCE_MAX and wraps.
  - On each wrap, hold_cnt++, saturating at LONG_MAX.
  - key_long pulses for one cycle on the edge where hold_cnt reaches LONG_MAX. A long_done flag blocks any repeat.
  - Released seen → RELEASE_FILT, dbc_cnt=0.
- RELEASE_FILT:
  - Pressed seen → PRESSED. No pulse. hold_cnt and long_done are kept; tick_cnt restarts at 0.
  - dbc_cnt==DEBOUNCE_MAX while still released → IDLE; key_release=1 for one cycle; key_state=0; long_done cleared.
- Latency:
  - Count key_in changing as sampled at edge 1. If the level then stays stable, key_press or key_release goes high exactly at edge DEBOUNCE_MAX+4.
  - key_long goes high at edge DEBOUNCE_MAX+4+LONG_MAX*(DEBOUNCE_MAX+1).
- Pulses are registered. At most one event pulse is high in any cycle. key_press and key_release never occur in the same cycle.
- Glitches:
  - Any excursion shorter than DEBOUNCE_MAX+1 synchronised cycles produces no event.
  - key_state does not change during filtering.
- Reset asserted in any state: everything returns to reset values on that edge. A key still held after reset is treated as a fresh press with full latency.
- Counter widths: dbc_cnt and tick_cnt are 20 bits; hold_cnt is 6 bits. Counters never exceed their MAX value.

Decomposition:
- Shared package/header key_pkg: state encodings (IDLE=2'd0, PRESS_FILT=2'd1, PRESSED=2'd2, RELEASE_FILT=2'd3), default DEBOUNCE_MAX, default LONG_MAX.
- Sub-module key_sync: 2-FF synchroniser with reset value as a parameter. It is reused by future multi-key blocks.
- FSM, counters and pulse registers live in key_debounce_fsm.

Test Plan:
All cases use DEBOUNCE_MAX=9, LONG_MAX=3, KEY_ACTIVE_LOW=1.
1. Reset: sys_rst=1 for 3 cycles with key_in=0 → all outputs 0 throughout. Deassert with key_in=1 held for 50 cycles → no pulses.
2. Clean press: key_in 1→0 (sampled at edge 1), held 20 cycles → key_press=1 only at edge 13; key_state=1 from edge 13.
3. Bounce: key_in low 5, high 3, low 4, then low held → no pulse during the bounce; a single key_press 13 edges after the final falling sample.
4. Long press: key_in held low 60 cycles → key_press at edge 13, key_long at edge 43 only, no second key_long. Release → key_release 13 edges later, key_state=0.
5. Release glitch: while PRESSED, key_in high for 6 cycles then low → no key_release, no extra key_press, key_state stays 1. A subsequent held release gives key_release at edge 13 of that release.
6. Mid-operation reset: sys_rst=1 for 1 cycle during PRESS_FILT with key_in held low → no key_press from the aborted filter. key_press at edge 13 counted from the first edge after reset deasserts.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and default timing for key debouncers
package key_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_FILT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_FILT = 2'd3
  } key_fsm_e;
  localparam logic [19:0] DEBOUNCE_MAX_DEF = 20'd999_999;
  localparam logic [5:0]  LONG_MAX_DEF     = 6'd49;
endpackage

// File: rtl/key_sync.sv
// key_sync: two-flop synchroniser with a parameterised reset level
module key_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic async_bit,
  output logic sync_bit
);
  logic meta;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) {sync_bit, meta} <= {2{RST_VAL}};
    else {sync_bit, meta} <= {meta, async_bit};
  end
endmodule

// File: rtl/key_debounce_fsm.sv
// key_debounce_fsm: synchronised, debounced key with press/release/long-press pulses
module key_debounce_fsm
  import key_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_MAX   = DEBOUNCE_MAX_DEF,
  parameter logic [5:0]  LONG_MAX       = LONG_MAX_DEF,
  parameter logic        KEY_ACTIVE_LOW = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_state
);
  logic        key_lvl, pressed, long_done;
  logic [19:0] dbc_cnt, tick_cnt;
  logic [5:0]  hold_cnt;
  key_fsm_e    state;
  key_sync #(.RST_VAL(KEY_ACTIVE_LOW)) u_sync (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .async_bit(key_in),
    .sync_bit (key_lvl)
  );
  assign pressed = key_lvl ^ KEY_ACTIVE_LOW;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      dbc_cnt     <= '0;
      tick_cnt    <= '0;
      hold_cnt    <= '0;
      long_done   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_state   <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      unique case (state)
        IDLE:
          if (pressed) begin
            state   <= PRESS_FILT;
            dbc_cnt <= '0;
          end
        PRESS_FILT:
          if (!pressed) state <= IDLE;
          else if (dbc_cnt == DEBOUNCE_MAX) begin
            state     <= PRESSED;
            key_press <= 1'b1;
            key_state <= 1'b1;
            hold_cnt  <= '0;
            tick_cnt  <= '0;
          end else dbc_cnt <= dbc_cnt + 20'd1;
        PRESSED:
          if (!pressed) begin
            state   <= RELEASE_FILT;
            dbc_cnt <= '0;
          end else if (tick_cnt == DEBOUNCE_MAX) begin
            tick_cnt <= '0;
            if (hold_cnt != LONG_MAX) hold_cnt <= hold_cnt + 6'd1;
            // long_done survives release glitches so one press yields one long pulse
            if (hold_cnt == LONG_MAX - 6'd1 && !long_done) begin
              key_long  <= 1'b1;
              long_done <= 1'b1;
            end
          end else tick_cnt <= tick_cnt + 20'd1;
        RELEASE_FILT:
          if (pressed) begin
            state    <= PRESSED;
            tick_cnt <= '0;
          end else if (dbc_cnt == DEBOUNCE_MAX) begin
            state       <= IDLE;
            key_release <= 1'b1;
            key_state   <= 1'b0;
            long_done   <= 1'b0;
          end else dbc_cnt <= dbc_cnt + 20'd1;
      endcase
    end
  end
endmodule

// File: tb/tb_key_debounce_fsm.sv
// tb_key_debounce_fsm: table-driven and directed checks of the key debouncer
module tb_key_debounce_fsm;
  localparam logic [19:0] DM = 20'd9;
  localparam logic [5:0]  LM = 6'd3;
  typedef struct {
    logic       rst;
    logic       key;
    int         n;
    logic [3:0] exp;
    string      tag;
  } vec_t;
  logic sys_clk = 1'b0, sys_rst = 1'b1, key_in = 1'b0;
  logic key_press, key_release, key_long, key_state;
  logic [3:0] outs;
  vec_t vecs[$];
  int chk_cnt = 0, pass_cnt = 0;
  always #5 sys_clk = ~sys_clk;
  key_debounce_fsm #(.DEBOUNCE_MAX(DM), .LONG_MAX(LM), .KEY_ACTIVE_LOW(1'b1)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_state  (key_state)
  );
  assign outs = {key_press, key_release, key_long, key_state};
  function automatic void add(input string tag, input logic r, input logic k, input int n,
                              input logic [3:0] e);
    vec_t v;
    v.rst = r;
    v.key = k;
    v.n   = n;
    v.exp = e;
    v.tag = tag;
    vecs.push_back(v);
  endfunction
  task automatic step(input logic r, input logic k);
    @(negedge sys_clk);
    sys_rst = r;
    key_in  = k;
    @(posedge sys_clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask
  // outputs are {press, release, long, state}
  initial begin
    int n, longs;
    add("t1_rst", 1, 0, 3, 4'b0000);
    add("t1_idle", 0, 1, 50, 4'b0000);
    add("t2_filt", 0, 0, 12, 4'b0000);
    add("t2_press", 0, 0, 1, 4'b1001);
    add("t2_hold", 0, 0, 7, 4'b0001);
    add("t2_rfilt", 0, 1, 12, 4'b0001);
    add("t2_rel", 0, 1, 1, 4'b0100);
    add("t2_idle", 0, 1, 7, 4'b0000);
    add("t3_lo5", 0, 0, 5, 4'b0000);
    add("t3_hi3", 0, 1, 3, 4'b0000);
    add("t3_lo4", 0, 0, 4, 4'b0000);
    add("t3_hi2", 0, 1, 2, 4'b0000);
    add("t3_filt", 0, 0, 12, 4'b0000);
    add("t3_press", 0, 0, 1, 4'b1001);
    add("t3_rfilt", 0, 1, 12, 4'b0001);
    add("t3_rel", 0, 1, 1, 4'b0100);
    add("t3_idle", 0, 1, 7, 4'b0000);
    add("t4_filt", 0, 0, 12, 4'b0000);
    add("t4_press", 0, 0, 1, 4'b1001);
    add("t4_hold", 0, 0, 29, 4'b0001);
    add("t4_long", 0, 0, 1, 4'b0011);
    add("t4_nolong", 0, 0, 17, 4'b0001);
    add("t4_rfilt", 0, 1, 12, 4'b0001);
    add("t4_rel", 0, 1, 1, 4'b0100);
    add("t4_idle", 0, 1, 7, 4'b0000);
    add("t5_filt", 0, 0, 12, 4'b0000);
    add("t5_press", 0, 0, 1, 4'b1001);
    add("t5_hold", 0, 0, 5, 4'b0001);
    add("t5_glitch", 0, 1, 6, 4'b0001);
    add("t5_back", 0, 0, 10, 4'b0001);
    add("t5_rfilt", 0, 1, 12, 4'b0001);
    add("t5_rel", 0, 1, 1, 4'b0100);
    add("t5_idle", 0, 1, 7, 4'b0000);
    add("t6_filt", 0, 0, 5, 4'b0000);
    add("t6_rst", 1, 0, 1, 4'b0000);
    add("t6_refilt", 0, 0, 12, 4'b0000);
    add("t6_press", 0, 0, 1, 4'b1001);
    add("t6_hold", 0, 0, 3, 4'b0001);
    add("t6_rfilt", 0, 1, 12, 4'b0001);
    add("t6_rel", 0, 1, 1, 4'b0100);
    add("t6_idle", 0, 1, 3, 4'b0000);
    foreach (vecs[i])
      for (int c = 0; c < vecs[i].n; c++) begin
        step(vecs[i].rst, vecs[i].key);
        check($sformatf("%s[%0d]", vecs[i].tag, c), {28'd0, outs}, {28'd0, vecs[i].exp});
      end
    // reset while pressed, key still held: a fresh press with full latency
    for (int c = 0; c < 20; c++) step(0, 0);
    check("pre_rst_state", {31'd0, key_state}, 32'd1);
    step(1, 0);
    check("rst_in_pressed", {28'd0, outs}, 32'd0);
    n = 0;
    do begin step(0, 0); n++; end while (!key_press && n < 40);
    check("repress_latency", n, 13);
    n = 0;
    do begin step(0, 0); n++; end while (!key_long && n < 60);
    check("long_latency", n, 30);
    longs = 0;
    for (int c = 0; c < 40; c++) begin
      step(0, 0);
      longs += int'(key_long);
    end
    check("long_repeat", longs, 0);
    n = 0;
    do begin step(0, 1); n++; end while (!key_release && n < 40);
    check("release_latency", n, 13);
    check("release_state", {31'd0, key_state}, 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
